// File: rtl/operand_bypass_pipe_if.sv
// Operand-source stage bus: ID-side register reads and tags, EX/DM results,
// and the operand/store-data/interlock outputs.
interface operand_bypass_pipe_if #(
    parameter int DW   = 16,
    parameter int AW   = 4,
    parameter int IMMW = 12
);
    logic            stall_ID_EX;
    logic            stall_EX_DM;
    logic            flush_ID_EX;
    logic [DW-1:0]   p0;
    logic [DW-1:0]   p1;
    logic [AW-1:0]   p0_addr;
    logic [AW-1:0]   p1_addr;
    logic            p0_rd;
    logic            p1_rd;
    logic [AW-1:0]   dst_addr_ID;
    logic            we_ID;
    logic            ld_ID;
    logic [IMMW-1:0] imm_ID_EX;
    logic [DW-1:0]   pc_ID_EX;
    logic [2:0]      src0sel_ID_EX;
    logic [1:0]      src1sel_ID_EX;
    logic [DW-1:0]   dst_EX_DM;
    logic [DW-1:0]   dst_DM_WB;
    logic [DW-1:0]   src0;
    logic [DW-1:0]   src1;
    logic [DW-1:0]   p0_EX_DM;
    logic            load_use_stall;

    modport master (
        output stall_ID_EX, stall_EX_DM, flush_ID_EX,
        output p0, p1, p0_addr, p1_addr, p0_rd, p1_rd,
        output dst_addr_ID, we_ID, ld_ID,
        output imm_ID_EX, pc_ID_EX, src0sel_ID_EX, src1sel_ID_EX,
        output dst_EX_DM, dst_DM_WB,
        input  src0, src1, p0_EX_DM, load_use_stall
    );

    modport slave (
        input  stall_ID_EX, stall_EX_DM, flush_ID_EX,
        input  p0, p1, p0_addr, p1_addr, p0_rd, p1_rd,
        input  dst_addr_ID, we_ID, ld_ID,
        input  imm_ID_EX, pc_ID_EX, src0sel_ID_EX, src1sel_ID_EX,
        input  dst_EX_DM, dst_DM_WB,
        output src0, src1, p0_EX_DM, load_use_stall
    );
endinterface

// File: rtl/operand_bypass_pipe.sv
// ID->EX operand stage with internal tag tracking, EX/DM/WB forwarding and load-use interlock.
// Optional macro OPBYP_WB_FWD_EN: write-through of DM_WB data at ID_EX capture.
module operand_bypass_pipe #(
    parameter int DW   = 16,
    parameter int AW   = 4,
    parameter int IMMW = 12
) (
    input logic clk,
    input logic rst,
    operand_bypass_pipe_if.slave bus
);

    logic [AW-1:0]   ie_addr, ie_a0, ie_a1;
    logic            ie_we, ie_ld, ie_rd0, ie_rd1;
    logic [DW-1:0]   p0_ie, p1_ie;
    // The load flag only matters for the interlock, so only ID_EX keeps it.
    logic [AW-1:0]   ed_addr, dw_addr;
    logic            ed_we, dw_we;

    logic [IMMW-1:0] imm;
    logic            lus;
    logic            m0_ex, m0_wb, m1_ex, m1_wb;
    logic [DW-1:0]   rf_p0, rf_p1;
    logic [DW-1:0]   cap_p0, cap_p1;

    assign imm = bus.imm_ID_EX;

    assign lus = ie_ld && ie_we && (ie_addr != '0) &&
                 ((bus.p0_rd && (bus.p0_addr == ie_addr)) ||
                  (bus.p1_rd && (bus.p1_addr == ie_addr)));
    assign bus.load_use_stall = lus;

`ifdef OPBYP_WB_FWD_EN
    assign cap_p0 = (bus.p0_rd && dw_we && (bus.p0_addr == dw_addr) && (bus.p0_addr != '0))
                    ? bus.dst_DM_WB : bus.p0;
    assign cap_p1 = (bus.p1_rd && dw_we && (bus.p1_addr == dw_addr) && (bus.p1_addr != '0))
                    ? bus.dst_DM_WB : bus.p1;
`else
    assign cap_p0 = bus.p0;
    assign cap_p1 = bus.p1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie_addr <= '0;
            ie_a0   <= '0;
            ie_a1   <= '0;
            ie_we   <= 1'b0;
            ie_ld   <= 1'b0;
            ie_rd0  <= 1'b0;
            ie_rd1  <= 1'b0;
            p0_ie   <= '0;
            p1_ie   <= '0;
        end else if (bus.flush_ID_EX || lus) begin
            ie_addr <= '0;
            ie_a0   <= '0;
            ie_a1   <= '0;
            ie_we   <= 1'b0;
            ie_ld   <= 1'b0;
            ie_rd0  <= 1'b0;
            ie_rd1  <= 1'b0;
            p0_ie   <= '0;
            p1_ie   <= '0;
        end else if (!bus.stall_ID_EX) begin
            ie_addr <= bus.dst_addr_ID;
            ie_a0   <= bus.p0_addr;
            ie_a1   <= bus.p1_addr;
            ie_we   <= bus.we_ID;
            ie_ld   <= bus.ld_ID;
            ie_rd0  <= bus.p0_rd;
            ie_rd1  <= bus.p1_rd;
            p0_ie   <= cap_p0;
            p1_ie   <= cap_p1;
        end
    end

    // A stalled EX_DM still drains into DM_WB, so DM_WB sees a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ed_addr      <= '0;
            ed_we        <= 1'b0;
            dw_addr      <= '0;
            dw_we        <= 1'b0;
            bus.p0_EX_DM <= '0;
        end else if (!bus.stall_EX_DM) begin
            ed_addr      <= ie_addr;
            ed_we        <= ie_we;
            dw_addr      <= ed_addr;
            dw_we        <= ed_we;
            bus.p0_EX_DM <= rf_p0;
        end else begin
            dw_addr      <= '0;
            dw_we        <= 1'b0;
        end
    end

    always_comb begin
        m0_ex = ie_rd0 && ed_we && (ie_a0 == ed_addr) && (ie_a0 != '0);
        m0_wb = ie_rd0 && dw_we && (ie_a0 == dw_addr) && (ie_a0 != '0);
        m1_ex = ie_rd1 && ed_we && (ie_a1 == ed_addr) && (ie_a1 != '0);
        m1_wb = ie_rd1 && dw_we && (ie_a1 == dw_addr) && (ie_a1 != '0);
        rf_p0 = m0_ex ? bus.dst_EX_DM : (m0_wb ? bus.dst_DM_WB : p0_ie);
        rf_p1 = m1_ex ? bus.dst_EX_DM : (m1_wb ? bus.dst_DM_WB : p1_ie);
    end

    always_comb begin
        bus.src0 = '0;
        case (bus.src0sel_ID_EX)
            3'd0:    bus.src0 = rf_p0;
            3'd1:    bus.src0 = {{(DW-9){imm[8]}}, imm[8:0]};
            3'd2:    bus.src0 = {{(DW-12){imm[11]}}, imm[11:0]};
            3'd3:    bus.src0 = {{(DW-4){1'b0}}, imm[3:0]};
            default: bus.src0 = {{(DW-4){imm[3]}}, imm[3:0]};
        endcase
    end

    always_comb begin
        bus.src1 = '0;
        case (bus.src1sel_ID_EX)
            2'd0:    bus.src1 = rf_p1;
            2'd1:    bus.src1 = bus.pc_ID_EX;
            2'd2:    bus.src1 = {{(DW-4){imm[3]}}, imm[3:0]};
            default: bus.src1 = {{(DW-8){imm[7]}}, imm[7:0]};
        endcase
    end

endmodule

// File: tb/tb_operand_bypass_pipe.sv
// Scoreboard bench for operand_bypass_pipe: directed vectors push expectations,
// a negedge monitor pops and compares them.
module tb_operand_bypass_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    operand_bypass_pipe_if #(.DW(16), .AW(4), .IMMW(12)) bus ();

    operand_bypass_pipe #(.DW(16), .AW(4), .IMMW(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          cyc;
        int          kind;   // 0 src0, 1 src1, 2 p0_EX_DM, 3 load_use_stall
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    bit   done  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation scheduled for the current cycle.
    always @(negedge clk) begin
        logic [15:0] act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            case (e.kind)
                0:       act = bus.src0;
                1:       act = bus.src1;
                2:       act = bus.p0_EX_DM;
                default: act = {15'd0, bus.load_use_stall};
            endcase
            total++;
            if (e.cyc != cyc || act !== e.val) begin
                bad++;
                $display("FAIL %s: got %h want %h (cyc %0d/%0d)", e.name, act, e.val, cyc, e.cyc);
            end
        end
    end

    task automatic expect_v(input int kind, input logic [15:0] val, input string name);
        exp_t e;
        e.cyc = cyc; e.kind = kind; e.val = val; e.name = name;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id(input logic [15:0] p0, input logic [3:0] a0, input logic rd0,
                      input logic [15:0] p1, input logic [3:0] a1, input logic rd1,
                      input logic [3:0] dst, input logic we, input logic ld);
        bus.p0 = p0; bus.p0_addr = a0; bus.p0_rd = rd0;
        bus.p1 = p1; bus.p1_addr = a1; bus.p1_rd = rd1;
        bus.dst_addr_ID = dst; bus.we_ID = we; bus.ld_ID = ld;
    endtask

    task automatic nop();
        id(16'h0, 4'd0, 1'b0, 16'h0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [11:0] imm;
        logic [2:0]  s0;
        logic [1:0]  s1;
        logic [15:0] e0;
        logic [15:0] e1;
    } imm_vec_t;

    imm_vec_t iv[6];

    initial begin
        iv[0] = '{12'h9A5, 3'd1, 2'd1, 16'hFFA5, 16'hBEEF};
        iv[1] = '{12'h9A5, 3'd2, 2'd2, 16'hF9A5, 16'h0005};
        iv[2] = '{12'h35C, 3'd3, 2'd3, 16'h000C, 16'h005C};
        iv[3] = '{12'h35C, 3'd4, 2'd2, 16'hFFFC, 16'hFFFC};
        iv[4] = '{12'h35C, 3'd7, 2'd3, 16'hFFFC, 16'h005C};
        iv[5] = '{12'h35C, 3'd1, 2'd2, 16'hFF5C, 16'hFFFC};

        bus.stall_ID_EX = 1'b0; bus.stall_EX_DM = 1'b0; bus.flush_ID_EX = 1'b0;
        bus.imm_ID_EX = '0; bus.pc_ID_EX = 16'hBEEF;
        bus.src0sel_ID_EX = '0; bus.src1sel_ID_EX = '0;
        bus.dst_EX_DM = '0; bus.dst_DM_WB = '0;
        nop();

        // Reset state
        tick(); tick();
        expect_v(0, 16'h0000, "rst_src0");
        expect_v(1, 16'h0000, "rst_src1");
        expect_v(2, 16'h0000, "rst_p0_EX_DM");
        expect_v(3, 16'h0000, "rst_lus");
        tick();
        rst = 1'b0;
        tick();

        // EX forward: ADD r3, then reader of r3
        id(16'h0011, 4'd1, 1'b1, 16'h0, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0);
        tick();
        id(16'hDEAD, 4'd3, 1'b1, 16'h0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);
        tick();
        nop();
        bus.dst_EX_DM = 16'h1234;
        expect_v(0, 16'h1234, "ex_fwd_src0");
        expect_v(2, 16'h0011, "p0_EX_DM_plain");
        tick();
        expect_v(2, 16'h1234, "p0_EX_DM_fwd");

        // Immediate / pc selects
        for (int i = 0; i < 6; i++) begin
            bus.imm_ID_EX = iv[i].imm;
            bus.src0sel_ID_EX = iv[i].s0;
            bus.src1sel_ID_EX = iv[i].s1;
            expect_v(0, iv[i].e0, "imm_src0");
            expect_v(1, iv[i].e1, "imm_src1");
            tick();
        end
        bus.imm_ID_EX = '0; bus.src0sel_ID_EX = '0; bus.src1sel_ID_EX = '0;

        // Priority: r5 in EX_DM and DM_WB
        id(16'h0, 4'd0, 1'b0, 16'h0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0);
        tick();
        id(16'h0, 4'd0, 1'b0, 16'h0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0);
        tick();
        id(16'h0, 4'd0, 1'b0, 16'h0BAD, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0);
        tick();
        nop();
        bus.dst_EX_DM = 16'hAAAA; bus.dst_DM_WB = 16'h5555;
        expect_v(1, 16'hAAAA, "prio_src1");
        tick();

        // DM_WB-only forward on r6
        id(16'h0, 4'd0, 1'b0, 16'h0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0);
        tick();
        nop();
        tick();
        id(16'h0, 4'd0, 1'b0, 16'h0BAD, 4'd6, 1'b1, 4'd0, 1'b0, 1'b0);
        tick();
        nop();
        expect_v(1, 16'h5555, "wb_fwd_src1");
        tick();

        // Load-use on r2
        id(16'h0, 4'd0, 1'b0, 16'h0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1);
        tick();
        id(16'h0BAD, 4'd2, 1'b1, 16'h0, 4'd0, 1'b0, 4'd8, 1'b1, 1'b0);
        expect_v(3, 16'h0001, "lus_hi");
        tick();
        expect_v(3, 16'h0000, "lus_lo");
        expect_v(0, 16'h0000, "lus_bubble_src0");
        tick();
        nop();
        bus.dst_DM_WB = 16'h4242; bus.dst_EX_DM = 16'h7777;
        expect_v(0, 16'h4242, "lus_dm_fwd");
        expect_v(3, 16'h0000, "lus_after");
        tick();

        // r0 is never forwarded nor interlocked
        id(16'h0, 4'd0, 1'b0, 16'h0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1);
        tick();
        id(16'h0, 4'd0, 1'b1, 16'h0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        expect_v(3, 16'h0000, "r0_lus");
        tick();
        nop();
        bus.dst_EX_DM = 16'hFFFF;
        expect_v(0, 16'h0000, "r0_src0");
        tick();

        // WB write-through on r7
        id(16'h0, 4'd0, 1'b0, 16'h0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);
        tick();
        nop();
        tick();
        tick();
        id(16'h0, 4'd0, 1'b0, 16'h0000, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0);
        bus.dst_DM_WB = 16'h00FF;
        tick();
        nop();
        bus.dst_DM_WB = 16'h1111;
`ifdef OPBYP_WB_FWD_EN
        expect_v(1, 16'h00FF, "wb_thru_src1");
`else
        expect_v(1, 16'h0000, "wb_thru_src1");
`endif
        tick();

        // Stall holds ID_EX
        id(16'h0ABC, 4'd1, 1'b1, 16'h0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        id(16'hFFFF, 4'd1, 1'b1, 16'h0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        expect_v(0, 16'h0ABC, "pre_stall_src0");
        bus.stall_ID_EX = 1'b1;
        tick();
        expect_v(0, 16'h0ABC, "stall_hold_src0");
        bus.stall_ID_EX = 1'b0;
        nop();
        tick();

        // Flush during stall removes the forward
        id(16'h0, 4'd0, 1'b0, 16'h0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0);
        tick();
        id(16'h0321, 4'd9, 1'b1, 16'h0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        nop();
        bus.dst_EX_DM = 16'h9999;
        expect_v(0, 16'h9999, "preflush_fwd");
        bus.stall_ID_EX = 1'b1; bus.stall_EX_DM = 1'b1; bus.flush_ID_EX = 1'b1;
        tick();
        expect_v(0, 16'h0000, "flush_src0");
        bus.stall_ID_EX = 1'b0; bus.stall_EX_DM = 1'b0; bus.flush_ID_EX = 1'b0;
        tick();

        // Asynchronous reset mid-stream
        id(16'h5A5A, 4'd0, 1'b0, 16'h0, 4'd0, 1'b0, 4'd10, 1'b1, 1'b0);
        tick();
        tick();
        expect_v(2, 16'h5A5A, "pre_rst_p0_EX_DM");
        tick();
        rst = 1'b1;
        expect_v(2, 16'h0000, "async_rst_p0_EX_DM");
        tick();
        rst = 1'b0;
        id(16'h0777, 4'd10, 1'b1, 16'h0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        bus.dst_EX_DM = 16'h9999; bus.dst_DM_WB = 16'h8888;
        expect_v(2, 16'h0000, "post_rst_p0_EX_DM");
        tick();
        nop();
        expect_v(0, 16'h0777, "post_rst_no_fwd");
        tick();
        tick();

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL watchdog: got timeout want completion");
            $fatal(1, "timeout");
        end
    end

endmodule
